terminal_writer: RTL and testbench
==================================

TERMINAL_WRITER -- requirements
Module: terminal_writer

Interface
REQ-001 SHALL have parameter DISP_W, default 80, characters per row.
REQ-002 SHALL have parameter DISP_H, default 25, rows per screen.
REQ-003 SHALL have parameter SETUP_CYC, default 2, clocks of address/data valid before strobe.
REQ-004 SHALL have parameter STROBE_CYC, default 8, clocks cs_n plus we_n/oe_n held low.
REQ-005 SHALL have parameter HOLD_CYC, default 4, clocks of address/data held after strobe release.
REQ-006 SHALL have: clock  in  1  system clock; one clock domain only.
REQ-007 SHALL have: reset  in  1  reset; synchronous, active-high.
REQ-008 SHALL have: char_in  in  8  character code; char_valid  in  1; char_ready  out  1.
REQ-009 SHALL have: address  out  clog2(DISP_W*DISP_H)  frame-buffer cell address.
REQ-010 SHALL have: data_out  out  8; data_oe  out  1 (drive enable for external tristate); data_in  in  8.
REQ-011 SHALL have: cs_n, we_n, oe_n  out  1 each  active-low bus strobes.
REQ-012 SHALL have: cursor_col  out  clog2(DISP_W); cursor_row  out  clog2(DISP_H); busy  out  1.

Function
REQ-013 SHALL transfer a character only in a cycle where char_valid && char_ready; char_ready high only in state READY.
REQ-014 SHALL implement top states CLEAR, READY, PUTC, SCROLL_RD, SCROLL_WR, CLR_LINE; busy = !(state==READY).
REQ-015 SHALL run each bus access as IDLE -> SETUP (SETUP_CYC) -> STROBE (STROBE_CYC) -> HOLD (HOLD_CYC) -> IDLE; write = SETUP_CYC+STROBE_CYC+HOLD_CYC clocks.
REQ-016 SHALL keep address, data_out, data_oe constant from SETUP entry to HOLD exit; cs_n/we_n/oe_n high outside STROBE.
REQ-017 SHALL drive data_oe high only in write accesses; reads keep data_oe low and sample data_in on the last STROBE clock.
REQ-018 SHALL form address = row_base + cursor_col, row_base maintained by adding/subtracting DISP_W (no multiplier).
REQ-019 0x0D (CR): cursor_col <= 0, no bus access.
REQ-020 0x0A (LF): cursor_col <= 0, then newline.
REQ-021 0x08 (BS): cursor_col decrements if >0, else unchanged; no bus access.
REQ-022 0x0C (FF): enter CLEAR; cursor to (0,0).
REQ-023 Any other code: PUTC write at cursor, then cursor_col+1; at cursor_col==DISP_W-1 wrap to col 0 and newline.
REQ-024 Newline with cursor_row<DISP_H-1: cursor_row+1; at last row, see Configuration.
REQ-025 CLEAR SHALL write 0x20 to addresses 0..DISP_W*DISP_H-1 ascending, then enter READY.
REQ-026 cursor outputs SHALL update on the clock the triggering access completes (or the accept cycle for non-bus codes).

Reset
REQ-027 On reset: cs_n=we_n=oe_n=1, data_oe=0, address=0, data_out=0, char_ready=0, busy=1, cursor (0,0), state CLEAR.
REQ-028 Reset asserted mid-access SHALL abort it; strobes high on the next clock; the clear restarts from address 0.
REQ-029 After reset release, char_ready SHALL first rise after the full clear completes.

Configuration
REQ-030 Macro TERM_SCROLL_EN defined: newline on last row SHALL copy rows 1..DISP_H-1 up one row (SCROLL_RD/SCROLL_WR per cell, ascending address), then CLR_LINE writes 0x20 to the last row; cursor_row stays DISP_H-1.
REQ-031 Macro TERM_SCROLL_EN undefined: newline on last row SHALL set cursor_row 0, no bus accesses; SCROLL_RD, SCROLL_WR and CLR_LINE absent.

Structure
REQ-032 Package term_pkg SHALL hold the top-state enum, bus-phase enum, control-code constants (CR, LF, BS, FF, SPACE) and default timing constants.
REQ-033 Sub-module term_bus_cycle SHALL implement the REQ-015..REQ-017 access sequencer (start, is_write, done, rdata handshake).

Verification
REQ-034 Reset 1 clock, release -> exactly 2000 writes of 0x20 at addresses 0..1999, each 14 clocks; char_ready rises only afterwards.
REQ-035 Send 0x41 at (0,0) -> one write data 0x41 addr 0, cs_n/we_n low 8 clocks; cursor (1,0) after completion.
REQ-036 Send 80 x 0x42 from (0,0) -> addresses 0..79 written; cursor (0,1).
REQ-037 At (5,3) send 0x08, 0x0D -> no bus activity; cursor (4,3) then (0,3).
REQ-038 With TERM_SCROLL_EN, cursor (0,24), send 0x0A -> 1920 reads/writes moving addr n+80 to n, then 80 writes 0x20 at 1920..1999; cursor (0,24); without, cursor (0,0) and no bus activity.
REQ-039 Assert reset during STROBE of a PUTC -> strobes high next clock, data_oe 0; clear restarts at address 0.

Source files
------------

// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : term_pkg
//  Description : Shared types and constants for the terminal writer: top
//                state enum, bus phase enum, control codes and default
//                display/bus timing values.
//                Optional feature macro: TERM_SCROLL_EN (adds scroll states).
//  Revision    : 1.0 - initial release
// ============================================================================
package term_pkg;

    // Top-level writer states; the scroll states exist only when scrolling
    // is built in.
    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        READY     = 3'd1,
        PUTC      = 3'd2
`ifdef TERM_SCROLL_EN
        ,
        SCROLL_RD = 3'd3,
        SCROLL_WR = 3'd4,
        CLR_LINE  = 3'd5
`endif
    } term_state_t;

    // Phases of one external frame-buffer access.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_phase_t;

    // Control codes recognised by the writer.
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // Default geometry and bus timing.
    localparam int DEF_DISP_W     = 80;
    localparam int DEF_DISP_H     = 25;
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 8;
    localparam int DEF_HOLD_CYC   = 4;

    // Largest of three phase lengths, used to size the phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/terminal_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : terminal_writer_if
//  Description : Character input handshake, frame-buffer bus and cursor
//                status of the terminal writer. The master modport is the
//                writer; the slave modport is the character source / memory.
//                Optional feature macro: TERM_SCROLL_EN (no effect here).
//  Revision    : 1.0 - initial release
// ============================================================================
interface terminal_writer_if
    import term_pkg::*;
#(
    parameter int DISP_W = DEF_DISP_W,
    parameter int DISP_H = DEF_DISP_H
);
    localparam int ADDR_W = $clog2(DISP_W * DISP_H);
    localparam int COL_W  = $clog2(DISP_W);
    localparam int ROW_W  = $clog2(DISP_H);

    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data_out;
    logic              data_oe;
    logic [7:0]        data_in;
    logic              cs_n;
    logic              we_n;
    logic              oe_n;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              busy;

    modport master (
        input  char_in, char_valid, data_in,
        output char_ready, address, data_out, data_oe, cs_n, we_n, oe_n,
               cursor_col, cursor_row, busy
    );

    modport slave (
        output char_in, char_valid, data_in,
        input  char_ready, address, data_out, data_oe, cs_n, we_n, oe_n,
               cursor_col, cursor_row, busy
    );
endinterface
`default_nettype wire

// File: rtl/term_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : term_bus_cycle
//  Description : Sequencer for one frame-buffer access:
//                IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Address, data and
//                drive enable are latched on acceptance and held through HOLD.
//                A new request is taken in IDLE or on the final HOLD clock,
//                so back-to-back accesses run without a gap.
//                Optional feature macro: TERM_SCROLL_EN (no effect here).
//  Revision    : 1.0 - initial release
// ============================================================================
module term_bus_cycle
    import term_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              done,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              cs_n,
    output logic              we_n,
    output logic              oe_n,
    input  logic [7:0]        data_in
);
    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

    bus_phase_t        phase, phase_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              wr, wr_nx;
    logic              accept;
    logic [ADDR_W-1:0] address_nx;
    logic [7:0]        data_out_nx;
    logic              data_oe_nx;
    logic [7:0]        rdata_nx;

    // Phase register and latched access attributes.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase    <= IDLE;
            cnt      <= '0;
            wr       <= 1'b0;
            address  <= '0;
            data_out <= '0;
            data_oe  <= 1'b0;
            rdata    <= '0;
        end else begin
            phase    <= phase_nx;
            cnt      <= cnt_nx;
            wr       <= wr_nx;
            address  <= address_nx;
            data_out <= data_out_nx;
            data_oe  <= data_oe_nx;
            rdata    <= rdata_nx;
        end
    end

    // Phase sequencing, read sampling and request acceptance.
    always_comb begin
        phase_nx    = phase;
        cnt_nx      = cnt + 1'b1;
        wr_nx       = wr;
        address_nx  = address;
        data_out_nx = data_out;
        data_oe_nx  = data_oe;
        rdata_nx    = rdata;
        done        = 1'b0;
        accept      = 1'b0;
        case (phase)
            IDLE: begin
                cnt_nx = '0;
                accept = start;
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    phase_nx = STROBE;
                    cnt_nx   = '0;
                end
            end
            STROBE: begin
                if (cnt == STROBE_LAST) begin
                    phase_nx = HOLD;
                    cnt_nx   = '0;
                    if (!wr) rdata_nx = data_in;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    done       = 1'b1;
                    phase_nx   = IDLE;
                    cnt_nx     = '0;
                    data_oe_nx = 1'b0;
                    accept     = start;
                end
            end
            default: phase_nx = IDLE;
        endcase
        if (accept) begin
            phase_nx    = SETUP;
            cnt_nx      = '0;
            wr_nx       = is_write;
            address_nx  = addr;
            data_out_nx = wdata;
            data_oe_nx  = is_write;
        end
    end

    assign cs_n = (phase != STROBE);
    assign we_n = !((phase == STROBE) && wr);
    assign oe_n = !((phase == STROBE) && !wr);

endmodule
`default_nettype wire

// File: rtl/terminal_writer.sv
`default_nettype none
// ============================================================================
//  Module      : terminal_writer
//  Description : Character terminal front end. Accepts character codes,
//                interprets CR/LF/BS/FF, writes printable codes into an
//                external frame buffer and clears the screen after reset.
//                Optional feature macro: TERM_SCROLL_EN - newline on the last
//                row scrolls the screen up instead of wrapping to row 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module terminal_writer
    import term_pkg::*;
#(
    parameter int DISP_W     = DEF_DISP_W,
    parameter int DISP_H     = DEF_DISP_H,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic              clock,
    input  logic              reset,
    terminal_writer_if.master term
);
    localparam int ADDR_W = $clog2(DISP_W * DISP_H);
    localparam int COL_W  = $clog2(DISP_W);
    localparam int ROW_W  = $clog2(DISP_H);

    localparam logic [ADDR_W-1:0] W_STEP    = ADDR_W'(DISP_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DISP_W * DISP_H - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(DISP_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DISP_H - 1);
`ifdef TERM_SCROLL_EN
    // Last destination cell of the row move; the last row is blanked after.
    localparam logic [ADDR_W-1:0] MOVE_LAST = ADDR_W'((DISP_H - 1) * DISP_W - 1);
`endif

    term_state_t       state, state_nx;
    logic [COL_W-1:0]  col, col_nx;
    logic [ROW_W-1:0]  row, row_nx;
    logic [ADDR_W-1:0] row_base, row_base_nx;   // row * DISP_W, kept by add/sub
    logic [ADDR_W-1:0] ptr, ptr_nx;             // cell pointer for clear/scroll
    logic [7:0]        ch, ch_nx;               // character being written
    logic              newline;

    logic              bus_start;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_done;
    logic [7:0]        bus_rdata;

    // State and cursor registers; reset starts a full-screen clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            ptr      <= '0;
            ch       <= '0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            row      <= row_nx;
            row_base <= row_base_nx;
            ptr      <= ptr_nx;
            ch       <= ch_nx;
        end
    end

    // Next-state, cursor movement and newline handling.
    always_comb begin
        state_nx    = state;
        col_nx      = col;
        row_nx      = row;
        row_base_nx = row_base;
        ptr_nx      = ptr;
        ch_nx       = ch;
        newline     = 1'b0;
        case (state)
            CLEAR: begin
                if (bus_done) begin
                    if (ptr == LAST_ADDR) state_nx = READY;
                    else                  ptr_nx   = ptr + 1'b1;
                end
            end
            READY: begin
                if (term.char_valid) begin
                    case (term.char_in)
                        CH_CR: col_nx = '0;
                        CH_LF: begin
                            col_nx  = '0;
                            newline = 1'b1;
                        end
                        CH_BS: if (col != '0) col_nx = col - 1'b1;
                        CH_FF: begin
                            state_nx    = CLEAR;
                            col_nx      = '0;
                            row_nx      = '0;
                            row_base_nx = '0;
                            ptr_nx      = '0;
                        end
                        default: begin
                            ch_nx    = term.char_in;
                            state_nx = PUTC;
                        end
                    endcase
                end
            end
            PUTC: begin
                if (bus_done) begin
                    state_nx = READY;
                    if (col == LAST_COL) begin
                        col_nx  = '0;
                        newline = 1'b1;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end
`ifdef TERM_SCROLL_EN
            SCROLL_RD: begin
                if (bus_done) state_nx = SCROLL_WR;
            end
            SCROLL_WR: begin
                if (bus_done) begin
                    ptr_nx   = ptr + 1'b1;
                    state_nx = (ptr == MOVE_LAST) ? CLR_LINE : SCROLL_RD;
                end
            end
            CLR_LINE: begin
                if (bus_done) begin
                    if (ptr == LAST_ADDR) state_nx = READY;
                    else                  ptr_nx   = ptr + 1'b1;
                end
            end
`endif
            default: state_nx = CLEAR;
        endcase
        if (newline) begin
            if (row != LAST_ROW) begin
                row_nx      = row + 1'b1;
                row_base_nx = row_base + W_STEP;
            end else begin
`ifdef TERM_SCROLL_EN
                state_nx = SCROLL_RD;
                ptr_nx   = '0;
`else
                row_nx      = '0;
                row_base_nx = '0;
`endif
            end
        end
    end

    // Bus request for the state being entered, so the sequencer can latch
    // the next access on the same clock the current one completes.
    always_comb begin
        bus_start = 1'b0;
        bus_write = 1'b1;
        bus_addr  = ptr_nx;
        bus_wdata = CH_SPACE;
        case (state_nx)
            CLEAR: bus_start = 1'b1;
            PUTC: begin
                bus_start = 1'b1;
                bus_addr  = row_base_nx + ADDR_W'(col_nx);
                bus_wdata = ch_nx;
            end
`ifdef TERM_SCROLL_EN
            SCROLL_RD: begin
                bus_start = 1'b1;
                bus_write = 1'b0;
                bus_addr  = ptr_nx + W_STEP;
            end
            SCROLL_WR: begin
                bus_start = 1'b1;
                bus_wdata = bus_rdata;
            end
            CLR_LINE: bus_start = 1'b1;
`endif
            default: bus_start = 1'b0;
        endcase
    end

    term_bus_cycle #(
        .ADDR_W     (ADDR_W),
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) u_bus (
        .clock    (clock),
        .reset    (reset),
        .start    (bus_start),
        .is_write (bus_write),
        .addr     (bus_addr),
        .wdata    (bus_wdata),
        .done     (bus_done),
        .rdata    (bus_rdata),
        .address  (term.address),
        .data_out (term.data_out),
        .data_oe  (term.data_oe),
        .cs_n     (term.cs_n),
        .we_n     (term.we_n),
        .oe_n     (term.oe_n),
        .data_in  (term.data_in)
    );

    assign term.char_ready = (state == READY);
    assign term.busy       = (state != READY);
    assign term.cursor_col = col;
    assign term.cursor_row = row;

endmodule
`default_nettype wire

// File: tb/tb_terminal_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_terminal_writer
//  Description : Directed testbench for terminal_writer: reset state, screen
//                clear, printable/control codes from a vector table, row
//                wrap, last-row newline and reset during an access.
//                Optional feature macro: TERM_SCROLL_EN (scroll expectations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_terminal_writer;
    localparam int W = 80;
    localparam int H = 25;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;

    terminal_writer_if #(.DISP_W(W), .DISP_H(H)) bus ();

    terminal_writer #(.DISP_W(W), .DISP_H(H)) dut (
        .clock (clock),
        .reset (reset),
        .term  (bus)
    );

    always #5 clock = ~clock;

    // Frame-buffer model feeding reads.
    logic [7:0] mem [0:2047];
    assign bus.data_in = mem[bus.address];

    // Expected screen content, maintained from what the bench sends.
    int exp_scr [0:W*H-1];

    typedef struct {
        bit we;
        int addr;
        int data;
        int len;
        bit oe;
        int start;
    } acc_t;
    acc_t q[$];

    typedef struct {
        logic [7:0] c;
        int col;
        int row;
        int nacc;
        int addr;
        int data;
    } vec_t;
    vec_t tv [16];

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Bus monitor: records every strobe as one access.
    initial begin
        acc_t cur;
        int   slen;
        slen = 0;
        cur  = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clock);
            if (!bus.cs_n) begin
                if (slen == 0) begin
                    cur.we    = !bus.we_n;
                    cur.addr  = int'(bus.address);
                    cur.data  = int'(bus.data_out);
                    cur.oe    = bus.data_oe;
                    cur.start = cyc;
                end else if (int'(bus.address) != cur.addr ||
                             int'(bus.data_out) != cur.data) begin
                    cur.addr = -1;
                end
                slen++;
            end else if (slen > 0) begin
                cur.len = slen;
                q.push_back(cur);
                if (cur.we && cur.addr >= 0) mem[cur.addr] = cur.data[7:0];
                slen = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    endtask

    task automatic abort_run(input string what);
        nvec++;
        nfail++;
        $display("FAIL %s: timed out, got no response, expected completion", what);
        summary();
        $fatal(1, "run stopped after timeout");
    endtask

    task automatic wait_ready(input string what);
        bit ok;
        ok = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clock);
            if (bus.char_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) abort_run(what);
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready("ready_before_send");
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.char_valid = 1'b0;
        wait_ready("ready_after_send");
    endtask

    // Index of the first access that is not a 0x20 write at base+i, or -1.
    function automatic int first_bad_fill(input int from, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (!q[from+i].we || !q[from+i].oe || q[from+i].addr != base + i ||
                q[from+i].data != 'h20 || q[from+i].len != 8)
                return i;
        end
        return -1;
    endfunction

    task automatic apply_vec(input int idx);
        vec_t v;
        v = tv[idx];
        q.delete();
        send(v.c);
        check($sformatf("v%0d_col", idx), int'(bus.cursor_col), v.col);
        check($sformatf("v%0d_row", idx), int'(bus.cursor_row), v.row);
        check($sformatf("v%0d_naccess", idx), q.size(), v.nacc);
        if (v.nacc == 1 && q.size() == 1) begin
            check($sformatf("v%0d_addr", idx), q[0].addr, v.addr);
            check($sformatf("v%0d_data", idx), q[0].data, v.data);
            check($sformatf("v%0d_we_len", idx), q[0].we ? q[0].len : 0, 8);
            exp_scr[v.addr] = v.data;
        end
    endtask

    initial begin
        int  bad;
        bit  seen;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        tv[0]  = '{8'h41, 1, 0, 1, 0,    'h41};
        tv[1]  = '{8'h08, 0, 0, 0, 0,    0};
        tv[2]  = '{8'h08, 0, 0, 0, 0,    0};
        tv[3]  = '{8'h0A, 0, 2, 0, 0,    0};
        tv[4]  = '{8'h5A, 1, 2, 1, 160,  'h5A};
        tv[5]  = '{8'h0D, 0, 2, 0, 0,    0};
        tv[6]  = '{8'h0A, 0, 3, 0, 0,    0};
        tv[7]  = '{8'h61, 1, 3, 1, 240,  'h61};
        tv[8]  = '{8'h62, 2, 3, 1, 241,  'h62};
        tv[9]  = '{8'h63, 3, 3, 1, 242,  'h63};
        tv[10] = '{8'h64, 4, 3, 1, 243,  'h64};
        tv[11] = '{8'h65, 5, 3, 1, 244,  'h65};
        tv[12] = '{8'h08, 4, 3, 0, 0,    0};
        tv[13] = '{8'h0D, 0, 3, 0, 0,    0};
        tv[14] = '{8'h7E, 1, 3, 1, 240,  'h7E};
        tv[15] = '{8'h57, 1, 24, 1, 1920, 'h57};

        // Reset state after one clock of reset.
        @(negedge clock);
        check("rst_cs_n",       int'(bus.cs_n), 1);
        check("rst_we_n",       int'(bus.we_n), 1);
        check("rst_oe_n",       int'(bus.oe_n), 1);
        check("rst_data_oe",    int'(bus.data_oe), 0);
        check("rst_address",    int'(bus.address), 0);
        check("rst_data_out",   int'(bus.data_out), 0);
        check("rst_char_ready", int'(bus.char_ready), 0);
        check("rst_busy",       int'(bus.busy), 1);
        check("rst_col",        int'(bus.cursor_col), 0);
        check("rst_row",        int'(bus.cursor_row), 0);
        reset = 1'b0;
        q.delete();

        // Power-up clear: ready only after all cells are blanked.
        wait_ready("initial_clear");
        check("clear_count", q.size(), W*H);
        if (q.size() == W*H) begin
            check("clear_first_bad", first_bad_fill(0, 0, W*H), -1);
            bad = -1;
            for (int i = 1; i < W*H; i++)
                if (q[i].start - q[i-1].start != 14) begin bad = i; break; end
            check("clear_spacing_first_bad", bad, -1);
        end
        check("clear_busy_after", int'(bus.busy), 0);
        for (int i = 0; i < W*H; i++) exp_scr[i] = 'h20;

        // Single character, then backspaces back to and at column 0.
        for (int i = 0; i <= 2; i++) apply_vec(i);

        // A full row of 'B' wraps to the next row.
        q.delete();
        for (int i = 0; i < W; i++) send(8'h42);
        check("row_fill_count", q.size(), W);
        bad = -1;
        for (int i = 0; i < q.size(); i++)
            if (!q[i].we || q[i].addr != i || q[i].data != 'h42) begin bad = i; break; end
        check("row_fill_first_bad", bad, -1);
        check("row_fill_col", int'(bus.cursor_col), 0);
        check("row_fill_row", int'(bus.cursor_row), 1);
        for (int i = 0; i < W; i++) exp_scr[i] = 'h42;

        for (int i = 3; i <= 14; i++) apply_vec(i);

        // Line feeds down to the last row, then a character there.
        q.delete();
        for (int i = 0; i < 21; i++) send(8'h0A);
        check("lf_walk_row",     int'(bus.cursor_row), 24);
        check("lf_walk_col",     int'(bus.cursor_col), 0);
        check("lf_walk_naccess", q.size(), 0);
        apply_vec(15);

        // Newline on the last row.
        q.delete();
        send(8'h0A);
`ifdef TERM_SCROLL_EN
        check("scroll_count", q.size(), 2*(W*H-W) + W);
        if (q.size() == 2*(W*H-W) + W) begin
            bad = -1;
            for (int i = 0; i < W*H-W; i++) begin
                if (q[2*i].we || q[2*i].oe || q[2*i].addr != i + W ||
                    !q[2*i+1].we || q[2*i+1].addr != i ||
                    q[2*i+1].data != exp_scr[i+W] || q[2*i+1].len != 8) begin
                    bad = i;
                    break;
                end
            end
            check("scroll_move_first_bad", bad, -1);
            check("scroll_blank_first_bad", first_bad_fill(2*(W*H-W), W*H-W, W), -1);
        end
        check("scroll_col", int'(bus.cursor_col), 0);
        check("scroll_row", int'(bus.cursor_row), 24);
        for (int i = 0; i < W*H-W; i++) exp_scr[i] = exp_scr[i+W];
        for (int i = W*H-W; i < W*H; i++) exp_scr[i] = 'h20;
`else
        check("wrap_naccess", q.size(), 0);
        check("wrap_col", int'(bus.cursor_col), 0);
        check("wrap_row", int'(bus.cursor_row), 0);

        // Form feed from a non-home cursor clears the screen and homes.
        q.delete();
        send(8'h43);
        check("ff_pre_col", int'(bus.cursor_col), 1);
        q.delete();
        send(8'h0C);
        check("ff_count", q.size(), W*H);
        if (q.size() == W*H) check("ff_first_bad", first_bad_fill(0, 0, W*H), -1);
        check("ff_col", int'(bus.cursor_col), 0);
        check("ff_row", int'(bus.cursor_row), 0);
`endif

        // Reset asserted in the middle of a character write strobe.
        wait_ready("ready_before_abort");
        bus.char_in    = 8'h51;
        bus.char_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.char_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!bus.cs_n) begin seen = 1; break; end
        end
        if (!seen) abort_run("abort_strobe_start");
        repeat (3) @(negedge clock);
        check("abort_in_strobe", int'(bus.we_n), 0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_cs_n",       int'(bus.cs_n), 1);
        check("abort_we_n",       int'(bus.we_n), 1);
        check("abort_data_oe",    int'(bus.data_oe), 0);
        check("abort_char_ready", int'(bus.char_ready), 0);
        check("abort_row",        int'(bus.cursor_row), 0);
        reset = 1'b0;
        @(negedge clock);
        q.delete();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (q.size() >= 3) begin seen = 1; break; end
        end
        if (!seen) abort_run("abort_clear_restart");
        check("restart_first_bad", first_bad_fill(0, 0, 3), -1);
        check("restart_char_ready", int'(bus.char_ready), 0);

        summary();
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #2000000;
        abort_run("watchdog");
    end

endmodule
`default_nettype wire
